// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals for the two-port memory arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              io_req0_valid;
  logic              io_req0_ready;
  logic              io_req0_write;
  logic [ADDR_W-1:0] io_req0_addr;
  logic [DATA_W-1:0] io_req0_wdata;
  logic              io_rsp0_valid;
  logic [DATA_W-1:0] io_rsp0_data;

  logic              io_req1_valid;
  logic              io_req1_ready;
  logic              io_req1_write;
  logic [ADDR_W-1:0] io_req1_addr;
  logic [DATA_W-1:0] io_req1_wdata;
  logic              io_rsp1_valid;
  logic [DATA_W-1:0] io_rsp1_data;

  logic              io_mem_wrEna;
  logic [ADDR_W-1:0] io_mem_wrAddr;
  logic [DATA_W-1:0] io_mem_wrData;
  logic [ADDR_W-1:0] io_mem_rdAddr;
  logic [DATA_W-1:0] io_mem_rdData;
  logic [CNT_W-1:0]  io_conflicts;

  modport slave (
    input  io_req0_valid, io_req0_write, io_req0_addr, io_req0_wdata,
    input  io_req1_valid, io_req1_write, io_req1_addr, io_req1_wdata,
    input  io_mem_rdData,
    output io_req0_ready, io_rsp0_valid, io_rsp0_data,
    output io_req1_ready, io_rsp1_valid, io_rsp1_data,
    output io_mem_wrEna, io_mem_wrAddr, io_mem_wrData, io_mem_rdAddr,
    output io_conflicts
  );

  modport master (
    output io_req0_valid, io_req0_write, io_req0_addr, io_req0_wdata,
    output io_req1_valid, io_req1_write, io_req1_addr, io_req1_wdata,
    output io_mem_rdData,
    input  io_req0_ready, io_rsp0_valid, io_rsp0_data,
    input  io_req1_ready, io_rsp1_valid, io_rsp1_data,
    input  io_mem_wrEna, io_mem_wrAddr, io_mem_wrData, io_mem_rdAddr,
    input  io_conflicts
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a 1W/1R memory: independent round-robin per port,
// read-after-write same-address stall with a saturating conflict counter.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  logic [1:0]        wr_cand_s;
  logic [1:0]        rd_cand_s;
  logic              wr_sel_s;
  logic              rd_sel_s;
  logic              wr_gnt_s;
  logic              rd_any_s;
  logic              rd_gnt_s;
  logic              conflict_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [ADDR_W-1:0] rd_addr_s;

  logic              wr_last_r;
  logic              rd_last_r;
  logic              rsp0_valid_r;
  logic              rsp1_valid_r;
  logic [DATA_W-1:0] rsp0_data_r;
  logic [DATA_W-1:0] rsp1_data_r;
  logic [CNT_W-1:0]  conflicts_r;

  // Candidate selection for each port; a tie goes to the requester not served last.
  always_comb begin
    wr_cand_s = {bus.io_req1_valid &  bus.io_req1_write, bus.io_req0_valid &  bus.io_req0_write};
    rd_cand_s = {bus.io_req1_valid & ~bus.io_req1_write, bus.io_req0_valid & ~bus.io_req0_write};
    case (wr_cand_s)
      2'b11:   wr_sel_s = ~wr_last_r;
      2'b10:   wr_sel_s = 1'b1;
      default: wr_sel_s = 1'b0;
    endcase
    case (rd_cand_s)
      2'b11:   rd_sel_s = ~rd_last_r;
      2'b10:   rd_sel_s = 1'b1;
      default: rd_sel_s = 1'b0;
    endcase
    wr_addr_s  = wr_sel_s ? bus.io_req1_addr  : bus.io_req0_addr;
    wr_data_s  = wr_sel_s ? bus.io_req1_wdata : bus.io_req0_wdata;
    rd_addr_s  = rd_sel_s ? bus.io_req1_addr  : bus.io_req0_addr;
    wr_gnt_s   = (|wr_cand_s) & ~reset;
    rd_any_s   = (|rd_cand_s) & ~reset;
    // Async read port would see stale data for a same-cycle write, so hold the read off.
    conflict_s = wr_gnt_s & rd_any_s & (wr_addr_s == rd_addr_s);
    rd_gnt_s   = rd_any_s & ~conflict_s;
  end

  // Handshake and memory drive derived from the grants.
  always_comb begin
    bus.io_req0_ready = (wr_gnt_s & ~wr_sel_s) | (rd_gnt_s & ~rd_sel_s);
    bus.io_req1_ready = (wr_gnt_s &  wr_sel_s) | (rd_gnt_s &  rd_sel_s);
    bus.io_mem_wrEna  = wr_gnt_s;
    if (wr_gnt_s) begin
      bus.io_mem_wrAddr = wr_addr_s;
      bus.io_mem_wrData = wr_data_s;
    end else begin
      bus.io_mem_wrAddr = {ADDR_W{1'b0}};
      bus.io_mem_wrData = {DATA_W{1'b0}};
    end
    if (rd_gnt_s) begin
      bus.io_mem_rdAddr = rd_addr_s;
    end else begin
      bus.io_mem_rdAddr = {ADDR_W{1'b0}};
    end
  end

  // Pointers, registered read responses and the saturating conflict counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_last_r    <= 1'b1;
      rd_last_r    <= 1'b1;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_data_r  <= {DATA_W{1'b0}};
      rsp1_data_r  <= {DATA_W{1'b0}};
      conflicts_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_gnt_s) begin
        wr_last_r <= wr_sel_s;
      end
      if (rd_gnt_s) begin
        rd_last_r <= rd_sel_s;
      end
      rsp0_valid_r <= rd_gnt_s & ~rd_sel_s;
      rsp1_valid_r <= rd_gnt_s &  rd_sel_s;
      if (rd_gnt_s & ~rd_sel_s) begin
        rsp0_data_r <= bus.io_mem_rdData;
      end
      if (rd_gnt_s & rd_sel_s) begin
        rsp1_data_r <= bus.io_mem_rdData;
      end
      if (conflict_s && (conflicts_r != {CNT_W{1'b1}})) begin
        conflicts_r <= conflicts_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.io_rsp0_valid = rsp0_valid_r;
  assign bus.io_rsp1_valid = rsp1_valid_r;
  assign bus.io_rsp0_data  = rsp0_data_r;
  assign bus.io_rsp1_data  = rsp1_data_r;
  assign bus.io_conflicts  = conflicts_r;

endmodule
